led_flow_ctrl: RTL and testbench

- Parametrised running-light controller driving LED_W LEDs with four selectable patterns and four step rates.
- Step rate is either auto-cycled, one rate per sweep, or selected manually.
- Includes an enable/pause input and step/sweep strobes so higher-level demo logic can synchronise to it.
- Sits directly behind board LED pins; the only clock is the board oscillator.

---
 rtl/led_flow_ctrl.sv | 132 +++++++++++++
 tb/tb_led_flow_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_flow_ctrl.sv
// led_flow_ctrl -- running-light controller for LED_W board LEDs.
//
// Four patterns (shift-left, shift-right, ping-pong, fill) stepped at one of
// four rates. The pattern and rate are latched only at sweep boundaries, so a
// sweep never mixes modes or speeds. The rate either advances by one at every
// sweep end (SPEED_AUTO=1) or follows SPEED.
//
// Ports:
//   CLOCK       in   1      board clock, rising edge
//   RESET       in   1      asynchronous, active-low
//   EN          in   1      1 = run, 0 = pause (all state frozen)
//   MODE        in   2      pattern request, sampled at sweep end
//   SPEED_AUTO  in   1      1 = rotate speed each sweep, 0 = use SPEED
//   SPEED       in   2      manual speed request, sampled at sweep end
//   LED         out  LED_W  registered LED drive, 1 = on
//   STEP        out  1      pulse in the cycle LED shows a new step
//   SWEEP_DONE  out  1      pulse in the cycle a new sweep starts
//   SPEED_CUR   out  2      speed index in force

// One LED: decides whether lane IDX is lit for step s of pattern mode.
module led_flow_lane #(
    parameter int LED_W = 4,
    parameter int SW    = 3,
    parameter int IDX   = 0
) (
    input  logic [SW-1:0] s,
    input  logic [1:0]    mode,
    output logic          on
);
    localparam logic [SW-1:0] IDX_V  = SW'(IDX);
    localparam logic [SW-1:0] MIR_V  = SW'(LED_W - 1 - IDX);
    // Ping-pong return leg: step 2*LED_W-2-IDX lights lane IDX again.
    localparam logic [SW-1:0] BACK_V = SW'(2 * LED_W - 2 - IDX);

    always_comb begin
        on = 1'b0;
        unique case (mode)
            2'd0: on = (s == IDX_V);
            2'd1: on = (s == MIR_V);
            2'd2: on = (s == IDX_V) || ((IDX != 0) && (IDX != LED_W - 1) && (s == BACK_V));
            2'd3: on = (s >= IDX_V);
            default: on = 1'b0;
        endcase
    end
endmodule

module led_flow_ctrl #(
    parameter int LED_W     = 4,
    parameter int CNT_W     = 26,
    parameter int T_SLOW    = 50_000_000,
    parameter int T_MID     = 5_000_000,
    parameter int T_FAST    = 500_000,
    parameter int T_FASTEST = 50_000
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             EN,
    input  logic [1:0]       MODE,
    input  logic             SPEED_AUTO,
    input  logic [1:0]       SPEED,
    output logic [LED_W-1:0] LED,
    output logic             STEP,
    output logic             SWEEP_DONE,
    output logic [1:0]       SPEED_CUR
);
    localparam int SW = $clog2(2 * LED_W);
    // Last step index of a sweep: linear patterns vs ping-pong.
    localparam logic [SW-1:0] LAST_LIN = SW'(LED_W - 1);
    localparam logic [SW-1:0] LAST_PP  = SW'(2 * LED_W - 3);

    // Terminal count (T-1) for each speed index.
    function automatic logic [CNT_W-1:0] tmax_of(input logic [1:0] sp);
        case (sp)
            2'd0:    return CNT_W'(T_SLOW - 1);
            2'd1:    return CNT_W'(T_MID - 1);
            2'd2:    return CNT_W'(T_FAST - 1);
            default: return CNT_W'(T_FASTEST - 1);
        endcase
    endfunction

    logic [CNT_W-1:0] c, tmax;
    logic [SW-1:0]    s, s_nxt;
    logic [1:0]       mode_cur, mode_nxt, speed_nxt;
    logic             last, tick;
    logic [LED_W-1:0] dec;

    always_comb begin
        last      = (s == ((mode_cur == 2'd2) ? LAST_PP : LAST_LIN));
        tick      = EN && (c == tmax);
        speed_nxt = SPEED_AUTO ? SPEED_CUR + 2'd1 : SPEED;
        s_nxt     = last ? '0 : s + 1'b1;
        mode_nxt  = last ? MODE : mode_cur;
    end

    // LED decode looks at the post-tick step and mode so the registered LED
    // changes on the same edge as s and mode_cur.
    for (genvar i = 0; i < LED_W; i++) begin : g_lane
        led_flow_lane #(.LED_W(LED_W), .SW(SW), .IDX(i)) u_lane (
            .s    (s_nxt),
            .mode (mode_nxt),
            .on   (dec[i])
        );
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            c          <= '0;
            tmax       <= tmax_of(2'd0);
            s          <= '0;
            mode_cur   <= 2'd0;
            SPEED_CUR  <= 2'd0;
            LED        <= {{(LED_W-1){1'b0}}, 1'b1};
            STEP       <= 1'b0;
            SWEEP_DONE <= 1'b0;
        end else begin
            STEP       <= tick;
            SWEEP_DONE <= tick && last;
            if (tick) begin
                c        <= '0;
                s        <= s_nxt;
                mode_cur <= mode_nxt;
                LED      <= dec;
                if (last) begin
                    SPEED_CUR <= speed_nxt;
                    tmax      <= tmax_of(speed_nxt);
                end
            end else if (EN) begin
                c <= c + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_led_flow_ctrl.sv
// Directed bench for led_flow_ctrl with a step-level behavioural model that is
// compared against the DUT on every falling edge, plus literal checks along
// the test plan.
module tb_led_flow_ctrl;
    localparam int W = 4;

    logic         CLOCK = 1'b0;
    logic         RESET = 1'b0;
    logic         EN = 1'b0;
    logic [1:0]   MODE = 2'd0;
    logic         SPEED_AUTO = 1'b1;
    logic [1:0]   SPEED = 2'd0;
    logic [W-1:0] LED;
    logic         STEP, SWEEP_DONE;
    logic [1:0]   SPEED_CUR;

    int tests = 0;
    int fails = 0;

    led_flow_ctrl #(
        .LED_W(W), .CNT_W(4), .T_SLOW(8), .T_MID(4), .T_FAST(2), .T_FASTEST(1)
    ) dut (
        .CLOCK(CLOCK), .RESET(RESET), .EN(EN), .MODE(MODE),
        .SPEED_AUTO(SPEED_AUTO), .SPEED(SPEED), .LED(LED), .STEP(STEP),
        .SWEEP_DONE(SWEEP_DONE), .SPEED_CUR(SPEED_CUR)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int c;
        int s;
        int mode;
        int spd;
        bit step;
        bit sd;
    } mstate_t;

    mstate_t m;

    function automatic int per_of(int sp);
        case (sp)
            0: return 8;
            1: return 4;
            2: return 2;
            default: return 1;
        endcase
    endfunction

    function automatic logic [W-1:0] pat(int md, int st);
        int p;
        if (md == 3) return W'((1 << (st + 1)) - 1);
        if (md == 0) p = st;
        else if (md == 1) p = W - 1 - st;
        else p = (st < W) ? st : 2 * W - 2 - st;
        return W'(1 << p);
    endfunction

    function automatic mstate_t mnext(mstate_t cur, bit en, int md, bit au, int sp);
        mstate_t n;
        int len;
        n = cur;
        n.step = 0;
        n.sd = 0;
        if (!en) return n;
        if (cur.c + 1 >= per_of(cur.spd)) begin
            n.c = 0;
            n.step = 1;
            len = (cur.mode == 2) ? 2 * W - 2 : W;
            if (cur.s == len - 1) begin
                n.s = 0;
                n.sd = 1;
                n.mode = md;
                n.spd = au ? (cur.spd + 1) % 4 : sp;
            end else begin
                n.s = cur.s + 1;
            end
        end else begin
            n.c = cur.c + 1;
        end
        return n;
    endfunction

    function automatic mstate_t mreset();
        mstate_t r;
        r.c = 0; r.s = 0; r.mode = 0; r.spd = 0; r.step = 0; r.sd = 0;
        return r;
    endfunction

    always @(posedge CLOCK or negedge RESET) begin
        if (!RESET) m <= mreset();
        else        m <= mnext(m, EN, int'(MODE), SPEED_AUTO, int'(SPEED));
    end

    always @(negedge CLOCK) begin
        if (RESET) begin
            chk("model_led",   32'(LED),        32'(pat(m.mode, m.s)));
            chk("model_step",  32'(STEP),       32'(m.step));
            chk("model_sweep", 32'(SWEEP_DONE), 32'(m.sd));
            chk("model_speed", 32'(SPEED_CUR),  32'(m.spd));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge CLOCK);
    endtask

    logic [W-1:0] pp_seq [6];
    logic [W-1:0] fr_seq [7];

    initial begin
        pp_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
        fr_seq = '{4'b0011, 4'b0111, 4'b1111, 4'b1000, 4'b0100, 4'b0010, 4'b0001};

        // Reset state
        cyc(2);
        chk("rst_led",   32'(LED), 32'h1);
        chk("rst_step",  32'(STEP), 32'h0);
        chk("rst_sweep", 32'(SWEEP_DONE), 32'h0);
        chk("rst_speed", 32'(SPEED_CUR), 32'h0);

        // 1. Auto speed, mode 0
        RESET = 1'b1; EN = 1'b1; SPEED_AUTO = 1'b1; MODE = 2'd0;
        cyc(7);
        chk("t1_hold_led",  32'(LED), 32'h1);
        chk("t1_hold_step", 32'(STEP), 32'h0);
        cyc(1);
        chk("t1_first_led",  32'(LED), 32'h2);
        chk("t1_first_step", 32'(STEP), 32'h1);
        cyc(24);
        chk("t1_sw1_led",   32'(LED), 32'h1);
        chk("t1_sw1_done",  32'(SWEEP_DONE), 32'h1);
        chk("t1_sw1_speed", 32'(SPEED_CUR), 32'h1);
        cyc(16);
        chk("t1_sw2_speed", 32'(SPEED_CUR), 32'h2);
        cyc(8);
        chk("t1_sw3_speed", 32'(SPEED_CUR), 32'h3);
        cyc(4);
        chk("t1_sw4_speed", 32'(SPEED_CUR), 32'h0);
        chk("t1_sw4_done",  32'(SWEEP_DONE), 32'h1);

        // 2. Ping-pong, manual speed 3 (after one more T_SLOW mode-0 sweep)
        SPEED_AUTO = 1'b0; SPEED = 2'd3; MODE = 2'd2;
        cyc(31);
        chk("t2_pre_speed", 32'(SPEED_CUR), 32'h0);
        cyc(1);
        chk("t2_start_speed", 32'(SPEED_CUR), 32'h3);
        chk("t2_start_led",   32'(LED), 32'h1);
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            chk("t2_pp_led",  32'(LED), 32'(pp_seq[i]));
            chk("t2_pp_done", 32'(SWEEP_DONE), (i == 5) ? 32'h1 : 32'h0);
        end

        // 3. Fill, then shift-right requested mid-sweep
        MODE = 2'd3;
        cyc(6);
        chk("t3_fill0", 32'(LED), 32'h1);
        for (int i = 0; i < 7; i++) begin
            cyc(1);
            if (i == 0) MODE = 2'd1;
            chk("t3_seq_led", 32'(LED), 32'(fr_seq[i]));
        end

        // 4. Pause at C=5 of a T=8 step
        SPEED = 2'd0; MODE = 2'd0;
        cyc(1);
        chk("t4_speed0", 32'(SPEED_CUR), 32'h0);
        cyc(5);
        EN = 1'b0;
        cyc(20);
        chk("t4_pause_led",   32'(LED), 32'h1);
        chk("t4_pause_step",  32'(STEP), 32'h0);
        chk("t4_pause_speed", 32'(SPEED_CUR), 32'h0);
        EN = 1'b1;
        cyc(2);
        chk("t4_res_led", 32'(LED), 32'h1);
        cyc(1);
        chk("t4_res_step", 32'(STEP), 32'h1);
        chk("t4_res_led2", 32'(LED), 32'h2);

        // 5. Pause exactly at C==T-1
        cyc(7);
        EN = 1'b0;
        cyc(3);
        chk("t5_nostep", 32'(STEP), 32'h0);
        chk("t5_led",    32'(LED), 32'h2);
        EN = 1'b1;
        cyc(1);
        chk("t5_step", 32'(STEP), 32'h1);
        chk("t5_led2", 32'(LED), 32'h4);

        // 6. Async reset during a mode-2 sweep at speed 2
        MODE = 2'd2; SPEED = 2'd2;
        cyc(16);
        chk("t6_speed2", 32'(SPEED_CUR), 32'h2);
        cyc(5);
        #2 RESET = 1'b0;
        #1;
        chk("t6_async_led",   32'(LED), 32'h1);
        chk("t6_async_speed", 32'(SPEED_CUR), 32'h0);
        chk("t6_async_step",  32'(STEP), 32'h0);
        cyc(2);
        RESET = 1'b1;
        cyc(7);
        chk("t6_hold_led", 32'(LED), 32'h1);
        cyc(1);
        chk("t6_first_led",  32'(LED), 32'h2);
        chk("t6_first_step", 32'(STEP), 32'h1);

        // Free run with auto speed in ping-pong, checked by the model only
        SPEED_AUTO = 1'b1;
        cyc(200);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
